// File: rtl/ram_port_arbiter_if.sv
// Client handshake and RAM pin bundle for ram_port_arbiter.
// master: the environment (clients plus the RAM macro's read data).
// slave:  the arbiter itself.
interface ram_port_arbiter_if #(
  parameter int unsigned AW = 7,
  parameter int unsigned DW = 8
);
  // Client 0
  logic          req0;
  logic          wr0;
  logic [AW-1:0] adr0;
  logic [DW-1:0] wdata0;
  logic          gnt0;
  logic          rvalid0;
  logic [DW-1:0] rdata0;
  // Client 1
  logic          req1;
  logic          wr1;
  logic [AW-1:0] adr1;
  logic [DW-1:0] wdata1;
  logic          gnt1;
  logic          rvalid1;
  logic [DW-1:0] rdata1;
  // Status
  logic          busy;
  // RAM pins
  logic [AW-1:0] ram_adr_a;
  logic [DW-1:0] ram_din;
  logic          ram_we_n;
  logic [AW-1:0] ram_adr_b;
  logic [DW-1:0] ram_dout;

  modport master (
    output req0, wr0, adr0, wdata0,
    output req1, wr1, adr1, wdata1,
    output ram_dout,
    input  gnt0, rvalid0, rdata0,
    input  gnt1, rvalid1, rdata1,
    input  busy,
    input  ram_adr_a, ram_din, ram_we_n, ram_adr_b
  );

  modport slave (
    input  req0, wr0, adr0, wdata0,
    input  req1, wr1, adr1, wdata1,
    input  ram_dout,
    output gnt0, rvalid0, rdata0,
    output gnt1, rvalid1, rdata1,
    output busy,
    output ram_adr_a, ram_din, ram_we_n, ram_adr_b
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one two-port RAM (sync write port A, async read
// port B, active-low we) between two clients. After reset the whole RAM is
// swept to CLEAR_VAL, then the write and read ports are arbitrated
// independently with a two-client round-robin per port.
// Optional feature macro: RAM_ARB_BYPASS_EN -- a granted read hitting the
// address being written in the same cycle returns the new write data instead
// of the old RAM content.
module ram_port_arbiter #(
  parameter int unsigned   AW        = 7,
  parameter int unsigned   DW        = 8,
  parameter logic [DW-1:0] CLEAR_VAL = '0
) (
  input  logic              ck,
  input  logic              rst,
  ram_port_arbiter_if.slave bus
);

  // Extra top bit lets the sweep stop without wrapping back to address 0.
  localparam int unsigned CW = AW + 1;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   clr_cnt_q, clr_cnt_d;
  logic [CW-1:0]   clr_cnt_inc;
  logic            wptr_q, wptr_d;
  logic            rptr_q, rptr_d;
  logic            busy_q;
  logic            rvalid0_q, rvalid1_q;
  logic [DW-1:0]   rdata0_q, rdata1_q;

  logic            want_w0, want_w1, want_r0, want_r1;
  logic            gw0, gw1, gr0, gr1;
  logic            we_n;
  logic [AW-1:0]   adr_a, adr_b;
  logic [DW-1:0]   din;
  logic [DW-1:0]   rd_val;

  // Request classification per port.
  assign want_w0 = bus.req0 &  bus.wr0;
  assign want_w1 = bus.req1 &  bus.wr1;
  assign want_r0 = bus.req0 & ~bus.wr0;
  assign want_r1 = bus.req1 & ~bus.wr1;

  assign clr_cnt_inc = clr_cnt_q + CW'(1);

  // Next-state, arbitration and RAM pin drive.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    gw0       = 1'b0;
    gw1       = 1'b0;
    gr0       = 1'b0;
    gr1       = 1'b0;
    we_n      = 1'b1;
    adr_a     = '0;
    din       = '0;
    adr_b     = '0;

    case (state_q)
      CLEAR: begin
        we_n      = 1'b0;
        adr_a     = clr_cnt_q[AW-1:0];
        din       = CLEAR_VAL;
        clr_cnt_d = clr_cnt_inc;
        if (clr_cnt_inc[AW]) begin
          state_d = RUN;
        end
      end
      RUN: begin
        // On contention the client that did not win last time goes.
        gw0 = want_w0 & (~want_w1 |  wptr_q);
        gw1 = want_w1 & (~want_w0 | ~wptr_q);
        gr0 = want_r0 & (~want_r1 |  rptr_q);
        gr1 = want_r1 & (~want_r0 | ~rptr_q);
        if (gw0 | gw1) begin
          we_n   = 1'b0;
          adr_a  = gw1 ? bus.adr1   : bus.adr0;
          din    = gw1 ? bus.wdata1 : bus.wdata0;
          wptr_d = gw1;
        end
        if (gr0 | gr1) begin
          adr_b  = gr1 ? bus.adr1 : bus.adr0;
          rptr_d = gr1;
        end
      end
      default: begin
        state_d = CLEAR;
      end
    endcase

    // Nothing reaches the RAM or the clients while reset is held.
    if (rst) begin
      gw0   = 1'b0;
      gw1   = 1'b0;
      gr0   = 1'b0;
      gr1   = 1'b0;
      we_n  = 1'b1;
      adr_a = '0;
      din   = '0;
      adr_b = '0;
    end
  end

  // Read data source: old RAM content, or forwarded write data when enabled.
`ifdef RAM_ARB_BYPASS_EN
  assign rd_val = (!we_n && (adr_a == adr_b)) ? din : bus.ram_dout;
`else
  assign rd_val = bus.ram_dout;
`endif

  // State register, sweep counter, round-robin pointers and busy flag.
  always_ff @(posedge ck) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      wptr_q    <= 1'b1;
      rptr_q    <= 1'b1;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      busy_q    <= (state_d == CLEAR);
    end
  end

  // Registered read return path; rvalid is a single-cycle pulse.
  always_ff @(posedge ck) begin
    if (rst) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rvalid0_q <= gr0;
      rvalid1_q <= gr1;
      if (gr0) begin
        rdata0_q <= rd_val;
      end
      if (gr1) begin
        rdata1_q <= rd_val;
      end
    end
  end

  assign bus.gnt0      = gw0 | gr0;
  assign bus.gnt1      = gw1 | gr1;
  assign bus.rvalid0   = rvalid0_q;
  assign bus.rvalid1   = rvalid1_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;
  assign bus.busy      = busy_q;
  assign bus.ram_we_n  = we_n;
  assign bus.ram_adr_a = adr_a;
  assign bus.ram_din   = din;
  assign bus.ram_adr_b = adr_b;

endmodule
